unary_adder_nway: RTL and testbench
===================================

# unary_adder_nway

Parametrised N-input scaled unary adder for the unary arithmetic datapath. Consumes NUM_INPUTS unary bitstreams of INPUT_WIDTH bits each. Produces one INPUT_WIDTH-bit unary stream whose ones-count approximates the sum of the input ones divided by NUM_INPUTS. It decides output bits early from lower and upper bounds on the final sum. It also adds features the fixed two-input adder lacks: downstream backpressure, a frame restart, and a completion flag.

## Interface
- INPUT_WIDTH, 32, bits per input and output frame (W)
- NUM_INPUTS, 4, number of input streams (N), ≥2
- COUNT_WIDTH, $clog2(INPUT_WIDTH+1), per-stream counter width
- CMP_WIDTH, $clog2(2*NUM_INPUTS*INPUT_WIDTH+1), width of all bound/midpoint arithmetic
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse: clear all frame state and begin a new frame
- a  in  NUM_INPUTS  input bit per stream
- ready  in  NUM_INPUTS  ready[i]=1: a[i] is a valid stream bit this cycle
- y_ready  in  1  downstream accepts y this cycle
- y  out  1  output stream bit
- valid  out  1  y holds an unconsumed bit
- done  out  1  all W output bits emitted and accepted

## Operation
- Per-stream registers ones[i] and count[i] (COUNT_WIDTH). Output registers y_ones and y_count.
- Stream i accepts a[i] when ready[i] && count[i] < W. On accept: count[i]++, ones[i] += a[i]. A stream with count[i]==W ignores ready[i] (no wrap).
- Bounds are computed each cycle from registered state, all at CMP_WIDTH zero-extended:
  - L = Σ ones[i]
  - U = Σ (ones[i] + W − count[i])
  - M2 = N·(2·y_ones + W − y_count)
- An emission slot exists when y_count < W and (!valid || y_ready).
- In an emission slot, test in priority order:
  - M2 ≤ 2L: load y=1; y_ones++, y_count++; valid=1.
  - else M2 ≥ 2U: load y=0; y_count++; valid=1.
  - else: stall. valid goes to 0 if the old bit was accepted this cycle.
- At most one output bit per cycle. Input acceptance proceeds regardless of output stall.
- The decision uses pre-update state. Bits accepted this cycle affect decisions from the next cycle.
- Once all streams are complete (L==U), one of the two conditions always holds. The output then drains at one bit per cycle, subject to y_ready.
- With valid=1 and y_ready=0, y and valid hold and y_ones/y_count do not change.
- done = (y_count==W) && !valid, registered. Once done is set, inputs are ignored until start.
- start, when not in reset, clears ones, count, y_ones, y_count, y, valid and done. start has priority over same-cycle input accepts and emissions; those bits are discarded. start mid-frame aborts the frame.
- Required property: final y_ones is within ±1 of L_final/N. It equals the exact value when L_final is a multiple of N and all inputs arrive before any emission.

## Timing
- Reset, sampled on a rising clk edge with reset==0: all counters 0; y=0, valid=0, done=0. Reset overrides start.
- Reset mid-frame discards the frame. The first edge with reset==1 behaves as an idle state, identical to just after start.
- Output is registered. A bit decided from state S at edge k is visible after edge k.
- Best-case latency: first valid after the 3rd edge counting from the first edge with an accepted input when all streams feed every cycle. Worst case: first valid after all streams complete plus 1 edge.
- valid/y handshake: a transfer occurs on an edge with valid && y_ready. A new bit may be loaded on the same edge.
- done rises one edge after the W-th bit is accepted.

## Test plan
- N=2, W=4, all a=1, ready=11 every cycle, y_ready=1 -> first valid after edge 3; y stream 1111; done after the final acceptance; y_ones=4.
- N=2, W=4, all a=0 -> first valid after edge 3; y stream 0000; no bit ever 1.
- N=3, W=4, stream totals 4,4,1, all inputs complete before emission -> output 1110, y_ones=3.
- Backpressure: hold y_ready=0 for 5 cycles with valid=1 -> y, valid, y_count frozen; inputs still counted. Release -> exactly W bits total.
- Mid-frame start and mid-frame reset=0 -> all outputs 0 next cycle. A fresh all-ones frame then produces 1111.
- Random N=4, W=32 with random ready gaps and random y_ready (1000 frames) -> exactly W transfers per frame, and |y_ones − L/N| ≤ 1.

Source files
------------

// File: rtl/unary_adder_nway.sv
// rtl/unary_adder_nway.sv - N-input scaled unary adder with early output decisions from sum bounds
// Backpressured output handshake, frame restart via start, registered completion flag.
module unary_adder_nway #(
   parameter int INPUT_WIDTH = 32,
   parameter int NUM_INPUTS  = 4,
   parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
   parameter int CMP_WIDTH   = $clog2(2 * NUM_INPUTS * INPUT_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_INPUTS-1:0] a,
   input  logic [NUM_INPUTS-1:0] ready,
   input  logic                  y_ready,
   output logic                  y,
   output logic                  valid,
   output logic                  done
);

   localparam logic [COUNT_WIDTH-1:0] W_C = COUNT_WIDTH'(INPUT_WIDTH);
   localparam logic [CMP_WIDTH-1:0]   W_X = CMP_WIDTH'(INPUT_WIDTH);
   localparam logic [CMP_WIDTH-1:0]   N_X = CMP_WIDTH'(NUM_INPUTS);

   logic [COUNT_WIDTH-1:0] ones  [NUM_INPUTS];
   logic [COUNT_WIDTH-1:0] count [NUM_INPUTS];
   logic [COUNT_WIDTH-1:0] y_ones;
   logic [COUNT_WIDTH-1:0] y_count;

   logic [CMP_WIDTH-1:0] lower;
   logic [CMP_WIDTH-1:0] upper;
   logic [CMP_WIDTH-1:0] mid2;
   logic                 slot;
   logic                 take_one;
   logic                 take_zero;
   logic                 xfer;

   // Lower bound assumes every missing input bit is 0, upper bound assumes 1.
   always_comb begin
      lower = '0;
      upper = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         lower = lower + CMP_WIDTH'(ones[i]);
         upper = upper + CMP_WIDTH'(ones[i]) + W_X - CMP_WIDTH'(count[i]);
      end
      mid2      = N_X * ((CMP_WIDTH'(y_ones) << 1) + W_X - CMP_WIDTH'(y_count));
      xfer      = valid && y_ready;
      slot      = (y_count < W_C) && (!valid || y_ready);
      take_one  = slot && (mid2 <= (lower << 1));
      take_zero = slot && !take_one && (mid2 >= (upper << 1));
   end

   always_ff @(posedge clk) begin
      if (!reset || start) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            ones[i]  <= '0;
            count[i] <= '0;
         end
         y_ones  <= '0;
         y_count <= '0;
         y       <= 1'b0;
         valid   <= 1'b0;
         done    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!done && ready[i] && (count[i] < W_C)) begin
               count[i] <= count[i] + COUNT_WIDTH'(1);
               ones[i]  <= ones[i] + COUNT_WIDTH'(a[i]);
            end
         end
         if (take_one || take_zero) begin
            y       <= take_one;
            valid   <= 1'b1;
            y_count <= y_count + COUNT_WIDTH'(1);
            if (take_one)
               y_ones <= y_ones + COUNT_WIDTH'(1);
         end else if (xfer) begin
            valid <= 1'b0;
         end
         done <= (y_count == W_C) && !valid;
      end
   end

endmodule

// File: tb/tb_unary_adder_nway.sv
// tb/tb_unary_adder_nway.sv - self-checking bench for unary_adder_nway
// Directed small-frame scenarios plus randomized N=4, W=32 frames against an arithmetic model.
module tb_unary_adder_nway;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;

   logic [1:0] a2 = '0, rdy2 = '0;
   logic       yr2 = 1'b0, y2, v2, d2;
   logic [2:0] a3 = '0, rdy3 = '0;
   logic       yr3 = 1'b0, y3, v3, d3;
   logic [3:0] a4 = '0, rdy4 = '0;
   logic       yr4 = 1'b0, y4, v4, d4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   unary_adder_nway #(.INPUT_WIDTH(4), .NUM_INPUTS(2)) dut2 (
      .clk(clk), .reset(rst), .start(start), .a(a2), .ready(rdy2),
      .y_ready(yr2), .y(y2), .valid(v2), .done(d2));

   unary_adder_nway #(.INPUT_WIDTH(4), .NUM_INPUTS(3)) dut3 (
      .clk(clk), .reset(rst), .start(start), .a(a3), .ready(rdy3),
      .y_ready(yr3), .y(y3), .valid(v3), .done(d3));

   unary_adder_nway #(.INPUT_WIDTH(32), .NUM_INPUTS(4)) dut4 (
      .clk(clk), .reset(rst), .start(start), .a(a4), .ready(rdy4),
      .y_ready(yr4), .y(y4), .valid(v4), .done(d4));

   task automatic idle_inputs();
      a2 = '0; rdy2 = '0; yr2 = 1'b0;
      a3 = '0; rdy3 = '0; yr3 = 1'b0;
      a4 = '0; rdy4 = '0; yr4 = 1'b0;
   endtask

   task automatic pulse_start();
      idle_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Feeds two 4-bit streams MSB first, one bit per cycle, with y_ready held high.
   task automatic run2(input logic [3:0] s0, input logic [3:0] s1, output logic [3:0] ys,
                       output int nb, output int fv, output int dgap);
      int last;
      pulse_start();
      ys = '0; nb = 0; fv = -1; dgap = -1; last = -1;
      for (int c = 1; c <= 40; c++) begin
         yr2 = 1'b1;
         if (v2 && yr2) begin
            ys = {ys[2:0], y2}; nb++; last = c;
         end
         if (c <= 4) begin
            rdy2 = 2'b11; a2 = {s1[4-c], s0[4-c]};
         end else begin
            rdy2 = 2'b00; a2 = 2'b00;
         end
         @(posedge clk); #1;
         if (v2 && fv < 0) fv = c;
         if (d2) begin
            dgap = c - last;
            break;
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0; rst = 1'b1;
      n_cmp++;
      if ({y2, v2, d2, y3, v3, d3, y4, v4, d4} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b required 000000000", {y2, v2, d2, y3, v3, d3, y4, v4, d4});
      end
   endtask

   task automatic test_all_ones();
      logic [3:0] ys; int nb, fv, dg;
      run2(4'b1111, 4'b1111, ys, nb, fv, dg);
      n_cmp++; if (fv !== 3) begin n_bad++; $display("FAIL ones_first_valid: got %0d required 3", fv); end
      n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL ones_bits: got %0d required 4", nb); end
      n_cmp++; if (ys !== 4'b1111) begin n_bad++; $display("FAIL ones_stream: got %b required 1111", ys); end
      n_cmp++; if (dg !== 1) begin n_bad++; $display("FAIL ones_done_gap: got %0d required 1", dg); end
   endtask

   task automatic test_all_zeros();
      logic [3:0] ys; int nb, fv, dg;
      run2(4'b0000, 4'b0000, ys, nb, fv, dg);
      n_cmp++; if (fv !== 3) begin n_bad++; $display("FAIL zeros_first_valid: got %0d required 3", fv); end
      n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL zeros_bits: got %0d required 4", nb); end
      n_cmp++; if (ys !== 4'b0000) begin n_bad++; $display("FAIL zeros_stream: got %b required 0000", ys); end
   endtask

   task automatic test_three_inputs();
      logic [3:0] s0, s1, s2, ys;
      int nb, ones;
      s0 = 4'b1111; s1 = 4'b1111; s2 = 4'b1000;
      pulse_start();
      ys = '0; nb = 0; ones = 0;
      for (int c = 1; c <= 40 && !d3; c++) begin
         yr3 = 1'b1;
         if (v3) begin ys = {ys[2:0], y3}; nb++; ones += int'(y3); end
         if (c <= 4) begin
            rdy3 = 3'b111; a3 = {s2[4-c], s1[4-c], s0[4-c]};
         end else begin
            rdy3 = 3'b000; a3 = 3'b000;
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      n_cmp++; if (d3 !== 1'b1) begin n_bad++; $display("FAIL n3_done: got %b required 1", d3); end
      n_cmp++; if (ys !== 4'b1110) begin n_bad++; $display("FAIL n3_stream: got %b required 1110", ys); end
      n_cmp++; if (ones !== 9 / 3) begin n_bad++; $display("FAIL n3_ones: got %0d required 3", ones); end
   endtask

   task automatic test_backpressure();
      logic y0;
      int c, nb, ones;
      pulse_start();
      c = 0;
      while (c < 20 && !v2) begin
         c++;
         yr2 = 1'b0;
         rdy2 = (c <= 4) ? 2'b11 : 2'b00; a2 = rdy2;
         @(posedge clk); #1;
      end
      n_cmp++; if (v2 !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %b required 1", v2); end
      y0 = y2;
      for (int k = 0; k < 5; k++) begin
         c++;
         yr2 = 1'b0;
         rdy2 = (c <= 4) ? 2'b11 : 2'b00; a2 = rdy2;
         @(posedge clk); #1;
         n_cmp++;
         if ({v2, y2} !== {1'b1, y0}) begin
            n_bad++; $display("FAIL bp_hold_%0d: got v=%b y=%b required v=1 y=%b", k, v2, y2, y0);
         end
      end
      nb = 0; ones = 0;
      for (int k = 0; k < 30 && !d2; k++) begin
         c++;
         yr2 = 1'b1;
         if (v2) begin nb++; ones += int'(y2); end
         rdy2 = (c <= 4) ? 2'b11 : 2'b00; a2 = rdy2;
         @(posedge clk); #1;
      end
      idle_inputs();
      n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL bp_bits: got %0d required 4", nb); end
      n_cmp++; if (ones !== 4) begin n_bad++; $display("FAIL bp_ones: got %0d required 4", ones); end
   endtask

   task automatic test_abort(input bit use_reset);
      logic [3:0] ys; int nb, fv, dg;
      pulse_start();
      for (int c = 1; c <= 3; c++) begin
         yr2 = 1'b1; rdy2 = 2'b11; a2 = 2'b11;
         @(posedge clk); #1;
      end
      n_cmp++; if (v2 !== 1'b1) begin n_bad++; $display("FAIL abort_pre_valid(%0d): got %b required 1", use_reset, v2); end
      rdy2 = 2'b11; a2 = 2'b11;
      if (use_reset) rst = 1'b0; else start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0;
      n_cmp++;
      if ({y2, v2, d2} !== 3'b000) begin
         n_bad++; $display("FAIL abort_clear(%0d): got %b required 000", use_reset, {y2, v2, d2});
      end
      run2(4'b1111, 4'b1111, ys, nb, fv, dg);
      n_cmp++; if ({nb[3:0], ys} !== {4'd4, 4'b1111}) begin
         n_bad++; $display("FAIL abort_refill(%0d): got %0d bits %b required 4 bits 1111", use_reset, nb, ys);
      end
   endtask

   task automatic test_random();
      int cnt[4];
      int lsum, xfers, yones, diff;
      bit seen;
      for (int f = 0; f < 1000; f++) begin
         pulse_start();
         for (int i = 0; i < 4; i++) cnt[i] = 0;
         lsum = 0; xfers = 0; yones = 0; seen = 1'b0;
         for (int c = 0; c < 400; c++) begin
            yr4 = ($urandom_range(0, 3) != 0);
            if (v4 && yr4) begin xfers++; yones += int'(y4); end
            for (int i = 0; i < 4; i++) begin
               rdy4[i] = ($urandom_range(0, 7) != 0);
               a4[i]   = $urandom_range(0, 1) != 0;
               if (rdy4[i] && cnt[i] < 32 && !d4) begin
                  cnt[i]++; lsum += int'(a4[i]);
               end
            end
            @(posedge clk); #1;
            if (d4) begin seen = 1'b1; break; end
         end
         idle_inputs();
         diff = 4 * yones - lsum;
         n_cmp++; if (!seen) begin n_bad++; $display("FAIL rand_done_timeout frame %0d: got done=0 required 1", f); end
         n_cmp++; if (xfers !== 32) begin n_bad++; $display("FAIL rand_xfers frame %0d: got %0d required 32", f, xfers); end
         n_cmp++;
         if (diff < -4 || diff > 4) begin
            n_bad++; $display("FAIL rand_scale frame %0d: got y_ones=%0d required within 1 of %0d/4", f, yones, lsum);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_all_zeros();
      test_three_inputs();
      test_backpressure();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
